// File: rtl/uart_rx_fsm.sv
// Purpose : UART receive frame sequencer. It detects the start edge, tracks the edge and bit counters,
//           and strobes the sampler, the checkers and the deserializer at fixed edges of each bit.
// Latency : strobes are Moore decodes of the registered state. data_valid is high in the cycle after the stop bit's last edge.
// Backpressure: none. The line runs freely, so the downstream logic must take data_valid when it is raised.
//
// Ports:
//   CLK, RST               oversampling clock, async active-low reset
//   RX_IN                  serial line (idle high); only looked at in IDLE for the start edge
//   PAR_EN, Prescale       frame format, captured when a start edge is detected
//   strt_glitch, par_err,
//   stp_err                registered results from the start/parity/stop checkers
//   dat_samp_en            sampler enable, high whenever a frame is in progress
//   strt_chk_en, par_chk_en,
//   stp_chk_en, deser_en   one-cycle strobes at the mid-bit edge (P/2+2)
//   edge_cnt, bit_cnt      position inside the current bit / frame
//   data_valid             one-cycle pulse for an error-free frame
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6,
    parameter int BIT_W      = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               deser_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               data_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               par_en_q, par_en_d;
    logic               data_valid_q, data_valid_d;

    logic               last_edge;
    logic               mid_edge;
    logic [PRESC_W-1:0] edge_inc;

    // The frame format is captured at the start edge, so every decode below
    // uses the captured prescale and never the live input.
    assign last_edge = (edge_cnt_q == presc_q - PRESC_W'(1));
    // The 3-tap majority result is ready two edges after the bit centre.
    assign mid_edge  = (edge_cnt_q == (presc_q >> 1) + PRESC_W'(2));
    assign edge_inc  = last_edge ? '0 : edge_cnt_q + PRESC_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        data_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    // The detect cycle is edge 0 of the start bit.
                    state_d    = START;
                    edge_cnt_d = PRESC_W'(1);
                    presc_d    = Prescale;
                    par_en_d   = PAR_EN;
                end
            end
            START: begin
                edge_cnt_d = edge_inc;
                if (last_edge) begin
                    if (strt_glitch) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = BIT_W'(1);
                    end
                end
            end
            DATA: begin
                edge_cnt_d = edge_inc;
                if (last_edge) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                edge_cnt_d = edge_inc;
                if (last_edge) begin
                    state_d   = STOP;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            STOP: begin
                edge_cnt_d = edge_inc;
                if (last_edge) begin
                    state_d      = IDLE;
                    edge_cnt_d   = '0;
                    bit_cnt_d    = '0;
                    // The checker results are stable from mid-bit+1, so they are valid at the last edge.
                    data_valid_d = !stp_err && !(par_en_q && par_err);
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Moore strobe decodes. An unused state drives everything low, as IDLE does.
    always_comb begin
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        deser_en    = 1'b0;
        case (state_q)
            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = mid_edge;
            end
            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = mid_edge;
            end
            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = mid_edge;
            end
            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = mid_edge;
            end
            default: ;
        endcase
    end

    assign edge_cnt   = edge_cnt_q;
    assign bit_cnt    = bit_cnt_q;
    assign data_valid = data_valid_q;

endmodule
